// File: rtl/fan_pwm_if.sv
// Front-panel buttons in, fan drive and status out, for fan_pwm_controller.
// Buttons are raw level signals; there is no handshake on this boundary.
interface fan_pwm_if #(
   parameter int LEVELS = 4,
   parameter int CNT_W  = 8
);
   localparam int LVL_W = $clog2(LEVELS);

   logic             btn_up;
   logic             btn_down;
   logic             btn_off;
   logic [LVL_W-1:0] level;
   logic [CNT_W-1:0] duty;
   logic             pwm_out;
   logic             at_target;

   modport master (
      output btn_up, btn_down, btn_off,
      input  level, duty, pwm_out, at_target
   );

   modport slave (
      input  btn_up, btn_down, btn_off,
      output level, duty, pwm_out, at_target
   );
endinterface

// File: rtl/fan_pwm_controller.sv
// N-level fan controller: debounced up/down/off buttons, duty target per level, PWM stage.
// Define FAN_RAMP_EN for a slew-limited duty ramp; otherwise duty follows the target directly.
module fan_pwm_controller #(
   parameter int LEVELS       = 4,
   parameter int CNT_W        = 8,
   parameter int DEBOUNCE_CYC = 4,
   parameter int RAMP_DIV     = 16
) (
   input  logic      clk,
   input  logic      reset,
   fan_pwm_if.slave  bus
);
   localparam int LVL_W = $clog2(LEVELS);
   localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);
   localparam int STEP  = (2**CNT_W - 1) / (LEVELS - 1);
   localparam logic [CNT_W-1:0] DUTY_MAX = '1;
   localparam logic [LVL_W-1:0] LVL_TOP  = LVL_W'(LEVELS - 1);

   if (LEVELS < 2 || DEBOUNCE_CYC < 1 || RAMP_DIV < 1) begin : g_param_check
      $error("fan_pwm_controller: illegal parameter value");
   end

   // Button order in the vectors below: [0]=up, [1]=down, [2]=off.
   logic [2:0]      raw;
   logic [2:0]      deb;
   logic [2:0]      deb_q;
   logic [2:0]      press;
   logic [DB_W-1:0] db_cnt [3];

   logic [LVL_W-1:0] level;
   logic [CNT_W-1:0] duty;
   logic [CNT_W-1:0] target;
   logic [CNT_W-1:0] pwm_cnt;
   logic             pwm_out;

   assign raw   = {bus.btn_off, bus.btn_down, bus.btn_up};
   assign press = deb & ~deb_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         deb   <= '0;
         deb_q <= '0;
         for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      end else begin
         deb_q <= deb;
         for (int i = 0; i < 3; i++) begin
            if (raw[i] != deb[i]) begin
               if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                  deb[i]    <= raw[i];
                  db_cnt[i] <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + 1'b1;
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   // Off wins; simultaneous up and down cancel each other.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level <= '0;
      end else if (press[2]) begin
         level <= '0;
      end else if (press[0] && !press[1]) begin
         if (level != LVL_TOP) level <= level + 1'b1;
      end else if (press[1] && !press[0]) begin
         if (level != '0) level <= level - 1'b1;
      end
   end

   always_comb begin
      target = '0;
      if (level == LVL_TOP) target = DUTY_MAX;
      else                  target = CNT_W'(int'(level) * STEP);
   end

`ifdef FAN_RAMP_EN
   localparam int RD_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   logic [RD_W-1:0] ramp_div;
   logic            ramp_wrap;

   assign ramp_wrap = (ramp_div == RD_W'(RAMP_DIV - 1));

   // Divider free-runs; a level change only redirects the next step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ramp_div <= '0;
         duty     <= '0;
      end else begin
         ramp_div <= ramp_wrap ? '0 : ramp_div + 1'b1;
         if (ramp_wrap && duty != target) begin
            if (duty < target) duty <= duty + 1'b1;
            else               duty <= duty - 1'b1;
         end
      end
   end
`else
   always_ff @(posedge clk or posedge reset) begin
      if (reset) duty <= '0;
      else       duty <= target;
   end
`endif

   // Period is 2^CNT_W-1 so that the full-scale duty gives a constant high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pwm_cnt <= '0;
         pwm_out <= 1'b0;
      end else begin
         pwm_cnt <= (pwm_cnt == DUTY_MAX - 1'b1) ? '0 : pwm_cnt + 1'b1;
         pwm_out <= (pwm_cnt < duty);
      end
   end

   assign bus.level     = level;
   assign bus.duty      = duty;
   assign bus.pwm_out   = pwm_out;
   assign bus.at_target = (duty == target);
endmodule

// File: tb/tb_fan_pwm_controller.sv
// Bench for fan_pwm_controller: vector table, hand sequences, random presses vs a reference model.
// Works in both builds (FAN_RAMP_EN defined or not).
module tb_fan_pwm_controller;
   localparam int LEVELS = 4;
   localparam int CNT_W  = 8;
   localparam int DEB    = 4;
   localparam int RDIV   = 16;
   localparam int MAXD   = 2**CNT_W - 1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fan_pwm_if #(.LEVELS(LEVELS), .CNT_W(CNT_W)) bus ();

   fan_pwm_controller #(
      .LEVELS(LEVELS), .CNT_W(CNT_W), .DEBOUNCE_CYC(DEB), .RAMP_DIV(RDIV)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   // ---------------- reference model ----------------
   int         n_edges;
   int         m_level;
   int         m_duty;
   bit         m_pwm;
   logic [2:0] m_deb;
   logic [2:0] m_prev;
   logic [2:0] samp_q[$];

   function automatic int tgt(input int l);
      return (l == LEVELS - 1) ? MAXD : l * (MAXD / (LEVELS - 1));
   endfunction

   always @(posedge clk or posedge reset) begin
      logic [2:0] raw;
      logic [2:0] p;
      int         lvl_old;
      int         duty_old;
      bit         all_diff;
      if (reset) begin
         n_edges = 0;
         m_level = 0;
         m_duty  = 0;
         m_pwm   = 1'b0;
         m_deb   = '0;
         m_prev  = '0;
         samp_q.delete();
      end else begin
         raw      = {bus.btn_off, bus.btn_down, bus.btn_up};
         lvl_old  = m_level;
         duty_old = m_duty;
         n_edges++;
         // PWM phase is just the edge count modulo the period.
         m_pwm = ((n_edges - 1) % MAXD) < duty_old;
`ifdef FAN_RAMP_EN
         if ((n_edges % RDIV) == 0 && duty_old != tgt(lvl_old))
            m_duty = (duty_old < tgt(lvl_old)) ? duty_old + 1 : duty_old - 1;
`else
         m_duty = tgt(lvl_old);
`endif
         p = m_deb & ~m_prev;
         if (p[2])                m_level = 0;
         else if (p[0] && !p[1])  m_level = (lvl_old < LEVELS - 1) ? lvl_old + 1 : lvl_old;
         else if (p[1] && !p[0])  m_level = (lvl_old > 0) ? lvl_old - 1 : 0;
         m_prev = m_deb;
         // A button flips once the last DEB samples all disagree with it.
         samp_q.push_back(raw);
         if (samp_q.size() > DEB) void'(samp_q.pop_front());
         if (samp_q.size() == DEB) begin
            for (int i = 0; i < 3; i++) begin
               all_diff = 1'b1;
               foreach (samp_q[j]) if (samp_q[j][i] == m_deb[i]) all_diff = 1'b0;
               if (all_diff) m_deb[i] = raw[i];
            end
         end
      end
   end

   // Cycle-by-cycle scoreboard against the model.
   always @(negedge clk) begin
      if (mon_en) begin
         checks++;
         if (int'(bus.level) != m_level || int'(bus.duty) != m_duty ||
             bus.pwm_out != m_pwm || bus.at_target != (m_duty == tgt(m_level))) begin
            errors++;
            $display("FAIL model_cmp t=%0t level=%0d exp %0d duty=%0d exp %0d pwm=%0b exp %0b at_target=%0b exp %0b",
                     $time, bus.level, m_level, bus.duty, m_duty, bus.pwm_out, m_pwm,
                     bus.at_target, (m_duty == tgt(m_level)));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int cyc);
      repeat (cyc) @(negedge clk);
   endtask

   task automatic push(input bit u, input bit d, input bit o, input int hold);
      @(negedge clk);
      bus.btn_up = u; bus.btn_down = d; bus.btn_off = o;
      idle(hold);
      bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_off = 1'b0;
      idle(10);
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   // kind 0: duty >= val, kind 1: duty <= val, kind 2: at_target high
   task automatic wait_for(input int kind, input int val, input int budget, input string name);
      int  k;
      bit  hit;
      hit = 1'b0;
      for (k = 0; k < budget && !hit; k++) begin
         @(negedge clk);
         case (kind)
            0:       hit = (int'(bus.duty) >= val);
            1:       hit = (int'(bus.duty) <= val);
            default: hit = bus.at_target;
         endcase
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL %s timed out after %0d cycles duty=%0d", name, budget, bus.duty);
      end
   endtask

   task automatic hold_pwm(input bit exp, input int cyc, input string name);
      int bad;
      bad = 0;
      repeat (cyc) begin
         @(negedge clk);
         if (bus.pwm_out != exp) bad++;
      end
      check_int(name, bad, 0);
   endtask

   typedef struct {
      bit up;
      bit dn;
      bit off;
      int hold;
      int exp_level;
      int exp_duty;
   } vec_t;

   vec_t vecs[12];

   initial begin
      vecs[0]  = '{1, 0, 0, 10, 1, 85};   // long hold gives exactly one event
      vecs[1]  = '{1, 0, 0, 3,  1, 85};   // short glitch ignored
      vecs[2]  = '{1, 0, 0, 6,  2, 170};
      vecs[3]  = '{1, 0, 0, 6,  3, 255};
      vecs[4]  = '{1, 0, 0, 6,  3, 255};  // saturate at top
      vecs[5]  = '{1, 1, 0, 6,  3, 255};  // up+down cancel
      vecs[6]  = '{0, 1, 0, 6,  2, 170};
      vecs[7]  = '{1, 1, 0, 6,  2, 170};
      vecs[8]  = '{1, 0, 1, 6,  0, 0};    // off beats up
      vecs[9]  = '{0, 1, 0, 6,  0, 0};    // saturate at bottom
      vecs[10] = '{1, 0, 0, 6,  1, 85};
      vecs[11] = '{0, 0, 1, 6,  0, 0};

      bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_off = 1'b0;
      reset = 1'b1;
      idle(3);
      check_int("reset_level", int'(bus.level), 0);
      check_int("reset_duty", int'(bus.duty), 0);
      check_int("reset_pwm", int'(bus.pwm_out), 0);
      check_int("reset_at_target", int'(bus.at_target), 1);
      reset = 1'b0;
      mon_en = 1'b1;

      foreach (vecs[i]) begin
         push(vecs[i].up, vecs[i].dn, vecs[i].off, vecs[i].hold);
         check_int($sformatf("vec%0d_level", i), int'(bus.level), vecs[i].exp_level);
`ifndef FAN_RAMP_EN
         check_int($sformatf("vec%0d_duty", i), int'(bus.duty), vecs[i].exp_duty);
`endif
      end

      // Full scale: pwm constant high, then off: constant low.
      repeat (3) push(1, 0, 0, 6);
      check_int("top_level", int'(bus.level), 3);
      wait_for(2, 0, 6000, "reach_255");
      check_int("top_duty", int'(bus.duty), 255);
      hold_pwm(1'b1, 300, "pwm_const_high");
      repeat (5) push(0, 1, 0, 6);
      check_int("bottom_level", int'(bus.level), 0);
      wait_for(2, 0, 6000, "reach_0");
      hold_pwm(1'b0, 300, "pwm_const_low");

      // Off while ramping up: duty turns around from where it is.
      repeat (3) push(1, 0, 0, 6);
      wait_for(0, 100, 3000, "ramp_to_100");
      push(0, 0, 1, 6);
      check_int("midramp_off_level", int'(bus.level), 0);
`ifdef FAN_RAMP_EN
      check_int("midramp_no_jump", int'(bus.duty >= 8'd90), 1);
`else
      check_int("midramp_off_duty", int'(bus.duty), 0);
`endif
      wait_for(1, 0, 3000, "ramp_down_to_0");

      // Asynchronous reset in the middle of a ramp.
      push(1, 0, 0, 6);
      wait_for(0, 40, 2000, "ramp_to_40");
      #2 reset = 1'b1;
      #1;
      check_int("async_rst_level", int'(bus.level), 0);
      check_int("async_rst_duty", int'(bus.duty), 0);
      check_int("async_rst_pwm", int'(bus.pwm_out), 0);
      check_int("async_rst_at_target", int'(bus.at_target), 1);
      idle(2);
      reset = 1'b0;

      // Random button activity, scored by the model every cycle.
      for (int r = 0; r < 60; r++) begin
         int sel;
         sel = $urandom_range(0, 9);
         @(negedge clk);
         bus.btn_up   = (sel < 5) || (sel == 8);
         bus.btn_down = (sel >= 4 && sel < 8);
         bus.btn_off  = (sel == 9) || (sel == 8);
         idle($urandom_range(1, 8));
         bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_off = 1'b0;
         idle($urandom_range(0, 10));
      end
      idle(20);

      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
